// File: rtl/lsu_axi_lite_if.sv
// Core-side request/response and data-memory bus signals of the load/store unit.
// slave is the LSU's view; master is the view of the core plus memory driving it.
interface lsu_axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [2:0]        req_funct3;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;
    logic              mem_resp_err;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_funct3,
               mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_funct3,
               mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/lsu_axi_lite.sv
// Load/store unit: turns one core memory operation into a valid/ready data-memory transaction.
// Build option LSU_MISALIGN_CHK_EN rejects misaligned half/word accesses before any bus request.
//   state | meaning
//   IDLE  | ready for a new core operation
//   REQ   | bus request presented, waiting for mem_req_ready
//   WAIT  | request accepted by the bus, waiting for mem_resp_valid
//   RESP  | one-cycle completion pulse to the core
module lsu_axi_lite #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           rst_n,
    lsu_axi_lite_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              mem_req_valid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_wen_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
    logic              wen_q;
    logic [1:0]        lsb_q;
    logic [2:0]        funct3_q;

    logic [3:0]        wstrb_d;
    logic [DATA_W-1:0] wdata_d;
    logic              illegal_d;
    logic              misalign_d;

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] lsb);
        logic [31:0] byte_w;
        logic [31:0] half_w;
        byte_w = word >> {lsb, 3'b000};
        half_w = word >> {lsb[1], 4'b0000};
        case (f3)
            3'b000:  return {{24{byte_w[7]}}, byte_w[7:0]};
            3'b100:  return {24'h000000, byte_w[7:0]};
            3'b001:  return {{16{half_w[15]}}, half_w[15:0]};
            3'b101:  return {16'h0000, half_w[15:0]};
            default: return word;
        endcase
    endfunction

`ifdef LSU_MISALIGN_CHK_EN
    assign misalign_d = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign_d = 1'b0;
`endif

    assign illegal_d = misalign_d ||
                       (bus.req_wen ? (bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11))
                                    : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11)));

    // Stores replicate the narrow value across every lane so strobes alone select the bytes.
    always_comb begin
        wstrb_d = 4'b0000;
        wdata_d = '0;
        if (bus.req_wen) begin
            case (bus.req_funct3)
                3'b000: begin
                    wstrb_d = 4'b0001 << bus.req_addr[1:0];
                    wdata_d = {4{bus.req_wdata[7:0]}};
                end
                3'b001: begin
                    wstrb_d = 4'b0011 << {bus.req_addr[1], 1'b0};
                    wdata_d = {2{bus.req_wdata[15:0]}};
                end
                3'b010: begin
                    wstrb_d = 4'b1111;
                    wdata_d = bus.req_wdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wstrb_q     <= 4'b0000;
            wen_q           <= 1'b0;
            lsb_q           <= 2'b00;
            funct3_q        <= 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        wen_q       <= bus.req_wen;
                        lsb_q       <= bus.req_addr[1:0];
                        funct3_q    <= bus.req_funct3;
                        req_ready_q <= 1'b0;
                        if (illegal_d) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state_q      <= RESP;
                        end else begin
                            mem_req_valid_q <= 1'b1;
                            mem_addr_q      <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            mem_wen_q       <= bus.req_wen;
                            mem_wdata_q     <= wdata_d;
                            mem_wstrb_q     <= wstrb_d;
                            state_q         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= bus.mem_resp_err;
                        resp_rdata_q <= (bus.mem_resp_err || wen_q) ? '0
                                        : load_ext(bus.mem_resp_rdata, funct3_q, lsb_q);
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_err      = resp_err_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wen       = mem_wen_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wstrb     = mem_wstrb_q;
endmodule

// File: tb/tb_lsu_axi_lite.sv
// Randomized self-checking bench for lsu_axi_lite against a transaction-level model.
// Honors LSU_MISALIGN_CHK_EN the same way the design does.
module tb_lsu_axi_lite;
    localparam int PH_OFF  = 0;
    localparam int PH_IDLE = 1;
    localparam int PH_BUS  = 2;
    localparam int PH_WAIT = 3;
    localparam int PH_DONE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_axi_lite_if bus_if();

    lsu_axi_lite #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_pulse = 0;
    int n_ops = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int resp_cyc = 0;
    int exp_phase = PH_OFF;

    logic        exp_wen, exp_ill, exp_rerr;
    logic [31:0] exp_maddr, exp_mwdata, exp_rdata;
    logic [3:0]  exp_strb;
    logic [31:0] last_maddr, last_mwdata, last_rdata;
    logic [3:0]  last_strb;
    logic        last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    // Expected bus fields and response of one operation, straight from the access rules.
    task automatic model_op(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3, input logic [31:0] rdata, input logic err);
        logic [31:0] b, h;
        int ofs;
        ofs = int'(addr % 32'd4);
        exp_wen = wen;
        exp_ill = wen ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 > 3'd5));
`ifdef LSU_MISALIGN_CHK_EN
        if ((f3 % 3'd4 == 3'd1) && (ofs % 2 != 0)) exp_ill = 1'b1;
        if ((f3 % 3'd4 == 3'd2) && (ofs != 0)) exp_ill = 1'b1;
`endif
        exp_maddr  = addr - 32'(ofs);
        exp_strb   = 4'd0;
        exp_mwdata = 32'd0;
        exp_rdata  = 32'd0;
        b = (rdata >> (8 * ofs)) & 32'hFF;
        h = (rdata >> (16 * (ofs / 2))) & 32'hFFFF;
        if (wen) begin
            case (f3)
                3'd0: begin exp_strb = 4'(1 << ofs); exp_mwdata = (wdata & 32'hFF) * 32'h01010101; end
                3'd1: begin exp_strb = 4'(3 << (ofs / 2 * 2)); exp_mwdata = (wdata & 32'hFFFF) * 32'h00010001; end
                3'd2: begin exp_strb = 4'hF; exp_mwdata = wdata; end
                default: ;
            endcase
        end else begin
            case (f3)
                3'd0: exp_rdata = (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
                3'd4: exp_rdata = b;
                3'd1: exp_rdata = (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
                3'd5: exp_rdata = h;
                3'd2: exp_rdata = rdata;
                default: ;
            endcase
        end
        exp_rerr = exp_ill || err;
        if (exp_rerr) exp_rdata = 32'd0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus_if.resp_valid) n_pulse <= n_pulse + 1;
        if (rst_n) begin
            case (exp_phase)
                PH_IDLE: chk("idle_ctrl", 32'({bus_if.req_ready, bus_if.resp_valid, bus_if.mem_req_valid}), 32'h4);
                PH_BUS: begin
                    chk("bus_ctrl", 32'({bus_if.req_ready, bus_if.resp_valid, bus_if.mem_req_valid, bus_if.mem_wen}),
                        32'({3'b001, exp_wen}));
                    chk("bus_addr", bus_if.mem_addr, exp_maddr);
                    chk("bus_wstrb", 32'(bus_if.mem_wstrb), 32'(exp_strb));
                    if (exp_wen) chk("bus_wdata", bus_if.mem_wdata, exp_mwdata);
                    last_maddr  <= bus_if.mem_addr;
                    last_strb   <= bus_if.mem_wstrb;
                    last_mwdata <= bus_if.mem_wdata;
                end
                PH_WAIT: chk("wait_ctrl", 32'({bus_if.req_ready, bus_if.resp_valid, bus_if.mem_req_valid}), 32'h0);
                PH_DONE: begin
                    chk("done_ctrl", 32'({bus_if.req_ready, bus_if.resp_valid, bus_if.resp_err, bus_if.mem_req_valid}),
                        32'({2'b01, exp_rerr, 1'b0}));
                    chk("done_rdata", bus_if.resp_rdata, exp_rdata);
                    last_rdata <= bus_if.resp_rdata;
                    last_err   <= bus_if.resp_err;
                    resp_cyc   <= cyc;
                end
                default: ;
            endcase
        end
    end

    task automatic scramble_req();
        bus_if.req_wen    = 1'($urandom % 2);
        bus_if.req_addr   = $urandom;
        bus_if.req_wdata  = $urandom;
        bus_if.req_funct3 = 3'($urandom % 8);
    endtask

    task automatic run_op(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic [31:0] rdata, input logic err,
                          input int rdly, input int wdly);
        model_op(wen, addr, wdata, f3, rdata, err);
        bus_if.req_valid  = 1'b1;
        bus_if.req_wen    = wen;
        bus_if.req_addr   = addr;
        bus_if.req_wdata  = wdata;
        bus_if.req_funct3 = f3;
        acc_cyc = cyc;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        scramble_req();
        if (!exp_ill) begin
            exp_phase = PH_BUS;
            for (int i = 0; i < rdly; i++) begin
                bus_if.mem_req_ready  = 1'b0;
                bus_if.mem_resp_valid = 1'($urandom % 2);
                bus_if.mem_resp_rdata = $urandom;
                bus_if.mem_resp_err   = 1'($urandom % 2);
                bus_if.req_valid      = 1'($urandom % 2);
                @(posedge clk); #1;
            end
            // A response in the handshake cycle itself must be ignored.
            bus_if.mem_req_ready  = 1'b1;
            bus_if.mem_resp_valid = 1'b1;
            bus_if.mem_resp_rdata = $urandom;
            bus_if.mem_resp_err   = 1'($urandom % 2);
            bus_if.req_valid      = 1'($urandom % 2);
            @(posedge clk); #1;
            exp_phase = PH_WAIT;
            for (int i = 0; i < wdly; i++) begin
                bus_if.mem_req_ready  = 1'($urandom % 2);
                bus_if.mem_resp_valid = 1'b0;
                bus_if.req_valid      = 1'($urandom % 2);
                @(posedge clk); #1;
            end
            bus_if.mem_req_ready  = 1'($urandom % 2);
            bus_if.mem_resp_valid = 1'b1;
            bus_if.mem_resp_rdata = rdata;
            bus_if.mem_resp_err   = err;
            @(posedge clk); #1;
            bus_if.mem_resp_valid = 1'b0;
        end
        exp_phase = PH_DONE;
        bus_if.req_valid = 1'($urandom % 2);
        @(posedge clk); #1;
        bus_if.req_valid      = 1'b0;
        bus_if.mem_req_ready  = 1'b0;
        bus_if.mem_resp_valid = 1'b0;
        exp_phase = PH_IDLE;
        n_ops++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctrl"}, 32'({bus_if.req_ready, bus_if.resp_valid, bus_if.resp_err, bus_if.mem_req_valid,
                                 bus_if.mem_wen, bus_if.mem_wstrb}), 32'h100);
        chk({tag, "_rdata"}, bus_if.resp_rdata, 32'd0);
        chk({tag, "_addr"}, bus_if.mem_addr, 32'd0);
        chk({tag, "_wdata"}, bus_if.mem_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.req_valid      = 1'b0;
        bus_if.mem_req_ready  = 1'b0;
        bus_if.mem_resp_valid = 1'b0;
        bus_if.mem_resp_rdata = 32'd0;
        bus_if.mem_resp_err   = 1'b0;
        scramble_req();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        exp_phase = PH_IDLE;
        @(posedge clk); #1;

        run_op(1'b0, 32'h80000104, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0, 0, 0);
        chk("lw_addr", last_maddr, 32'h80000104);
        chk("lw_wstrb", 32'(last_strb), 32'h0);
        chk("lw_rdata", last_rdata, 32'hDEADBEEF);
        chk("lw_err", 32'(last_err), 32'h0);
        chk("lw_latency", 32'(resp_cyc - acc_cyc), 32'd3);

        run_op(1'b0, 32'h80000103, 32'd0, 3'b000, 32'h80123456, 1'b0, 0, 0);
        chk("lb_rdata", last_rdata, 32'hFFFFFF80);
        run_op(1'b0, 32'h80000103, 32'd0, 3'b100, 32'h80123456, 1'b0, 0, 1);
        chk("lbu_rdata", last_rdata, 32'h00000080);
        run_op(1'b0, 32'h80000102, 32'd0, 3'b101, 32'hBEEF0000, 1'b0, 1, 0);
        chk("lhu_rdata", last_rdata, 32'h0000BEEF);

        run_op(1'b1, 32'h00000010, 32'h000000A5, 3'b000, 32'hFFFFFFFF, 1'b0, 0, 0);
        chk("sb_addr", last_maddr, 32'h00000010);
        chk("sb_wstrb", 32'(last_strb), 32'h1);
        chk("sb_wdata", last_mwdata, 32'hA5A5A5A5);
        chk("sb_rdata", last_rdata, 32'h0);
        run_op(1'b1, 32'h00000012, 32'h00001234, 3'b001, 32'hFFFFFFFF, 1'b0, 0, 0);
        chk("sh_wstrb", 32'(last_strb), 32'hC);
        chk("sh_wdata", last_mwdata, 32'h12341234);
        chk("sh_rdata", last_rdata, 32'h0);

        run_op(1'b0, 32'h00000020, 32'd0, 3'b010, 32'h0BADF00D, 1'b0, 5, 2);
        chk("bp_rdata", last_rdata, 32'h0BADF00D);
        chk("bp_latency", 32'(resp_cyc - acc_cyc), 32'd10);

        run_op(1'b0, 32'h00000044, 32'd0, 3'b010, 32'hFFFFFFFF, 1'b1, 0, 0);
        chk("buserr_err", 32'(last_err), 32'h1);
        chk("buserr_rdata", last_rdata, 32'h0);

        run_op(1'b0, 32'h00000100, 32'd0, 3'b110, 32'h12345678, 1'b0, 0, 0);
        chk("illegal_err", 32'(last_err), 32'h1);
        chk("illegal_latency", 32'(resp_cyc - acc_cyc), 32'd1);

        run_op(1'b0, 32'h00000002, 32'd0, 3'b010, 32'h11223344, 1'b0, 0, 0);
`ifdef LSU_MISALIGN_CHK_EN
        chk("misalign_err", 32'(last_err), 32'h1);
        chk("misalign_latency", 32'(resp_cyc - acc_cyc), 32'd1);
`else
        chk("lw_trunc_addr", last_maddr, 32'h00000000);
        chk("lw_trunc_rdata", last_rdata, 32'h11223344);
`endif

        // Reset while waiting for the bus, followed by a stale response.
        exp_phase = PH_OFF;
        bus_if.req_valid  = 1'b1;
        bus_if.req_wen    = 1'b0;
        bus_if.req_addr   = 32'h00000040;
        bus_if.req_funct3 = 3'b010;
        @(posedge clk); #1;
        bus_if.req_valid     = 1'b0;
        bus_if.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.mem_req_ready = 1'b0;
        chk("pre_rst_wait", 32'({bus_if.req_ready, bus_if.resp_valid, bus_if.mem_req_valid}), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_phase = PH_IDLE;
        bus_if.mem_resp_valid = 1'b1;
        bus_if.mem_resp_rdata = 32'h12345678;
        @(posedge clk); #1;
        bus_if.mem_resp_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        for (int k = 0; k < 150; k++) begin
            run_op(1'($urandom % 2), $urandom, $urandom, 3'($urandom % 8), $urandom,
                   1'(($urandom % 8) == 0), int'($urandom % 4), int'($urandom % 4));
            repeat (int'($urandom % 3)) begin
                bus_if.mem_resp_valid = 1'($urandom % 2);
                bus_if.mem_resp_rdata = $urandom;
                @(posedge clk); #1;
            end
            bus_if.mem_resp_valid = 1'b0;
        end

        @(posedge clk); #1;
        chk("resp_pulses", 32'(n_pulse), 32'(n_ops));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/lsu_axi_lite.md
Name: lsu_axi_lite

Overview:
- Load/store unit sitting directly downstream of the execute stage.
- Takes one memory operation per request (address = EX result, store data = rs2 value, funct3 from decode) and runs a valid/ready transaction on the data-memory bus.
- Returns aligned, sign/zero-extended load data to the register write-back path.
- Replaces the core's combinational data-memory access with a multi-cycle handshake, so the core must stall while req_ready is low.

Parameters:
ADDR_W, 32, address width of core and bus
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core presents an operation
req_ready  out  1  LSU idle, may accept
req_wen  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data (rs2 value)
req_funct3  in  3  RV32I width/sign code
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load result; 0 for stores
resp_err  out  1  operation failed (bus error or illegal funct3)
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_addr  out  32  word address {req_addr[31:2],2'b00}
mem_wen  out  1  bus write
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte strobes; 0000 on reads
mem_resp_valid  in  1  bus response valid
mem_resp_rdata  in  32  bus read word
mem_resp_err  in  1  bus error

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
  - mem_req_valid=0; mem_addr=0; mem_wen=0; mem_wdata=0; mem_wstrb=0.
  - Any in-flight bus transaction is abandoned. A mem_resp_valid arriving after reset is ignored.
- FSM IDLE -> REQ -> WAIT -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid: latch wen, addr[1:0], funct3; drive mem_* fields; go to REQ.
  - Illegal funct3 (loads 011/110/111; stores 011-111): go straight to RESP with resp_err=1, resp_rdata=0. No bus request.
- REQ:
  - mem_req_valid=1; fields held stable until mem_req_ready=1.
  - On handshake: drop mem_req_valid next cycle, go to WAIT.
  - Backpressure is unbounded.
- WAIT:
  - On mem_resp_valid: capture rdata/err, go to RESP.
  - mem_resp_valid outside WAIT is ignored, including in the handshake cycle.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Next state is IDLE; req_ready=1 again the following cycle.
- Minimum latency: accept at cycle 0, handshake cycle 1, response cycle 2, resp_valid cycle 3.
- Store strobes and data:
  - SB(000): wstrb=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH(001): wstrb=0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - SW(010): wstrb=1111.
- Loads: shift rdata right by 8*addr[1:0], then extend.
  - LB(000) sign-extend byte; LBU(100) zero-extend byte.
  - LH(001) sign-extend half; LHU(101) zero-extend half; LW(010) full word.
  - Halfword uses addr[1] only; word ignores addr[1:0].
- Error path: mem_resp_err=1 -> resp_err=1, resp_rdata=0.
- Stores: resp_rdata=0 always.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, goes IDLE -> RESP with resp_err=1, resp_rdata=0. No bus request is issued.
- Undefined: no check; low address bits are truncated per the rules above and the access proceeds normally.

Test Plan:
- LW addr 0x80000104, bus rdata 0xDEADBEEF, ready and response immediate -> mem_addr 0x80000104, wstrb 0000, resp_valid at cycle 3, rdata 0xDEADBEEF, err 0.
- LB addr 0x80000103, rdata 0x80123456 -> rdata 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x...02, rdata 0xBEEF0000 -> 0x0000BEEF.
- SB addr 0x10, wdata 0x000000A5 -> mem_addr 0x10, wstrb 0001, wdata 0xA5A5A5A5. SH addr 0x12, wdata 0x1234 -> wstrb 1100, wdata 0x12341234. resp_rdata 0 for both.
- mem_req_ready held low 5 cycles, then mem_resp_valid 3 cycles after handshake -> mem_req_valid and fields stable throughout, req_ready 0, exactly one resp_valid pulse.
- rst_n pulsed low during WAIT, stale mem_resp_valid arrives after release -> outputs at reset values immediately, stale response ignored, no resp_valid.
- Load with funct3 110 -> resp_err 1 at cycle 1, no mem_req_valid. With LSU_MISALIGN_CHK_EN: LW addr 0x2 -> resp_err 1, no bus request. Without it: LW addr 0x2 -> bus read at 0x0.
